intersection_controller: RTL
============================

Name: intersection_controller

Overview:
- Sequences a two-way intersection: north-south (NS) and east-west (EW) vehicle lights, plus the pedestrian crossing for each.
- Owns the master second counter (master_timer) that drives both pedestrian_light instances.
- Latches pedestrian push-button requests and grants the walk phase for a crossing only during that direction's green phase.
- Sits between the board clock/buttons and the two pedestrian_light blocks.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per one-second tick (bench uses 4).
- GREEN_TIME, 45, green phase length in seconds, 1..127.
- YELLOW_TIME, 5, yellow phase length in seconds, 1..127.
- ALL_RED_TIME, 2, all-red clearance length in seconds, 1..127.
- PED_EXTRA, 10, extra green seconds when PED_EXTEND_EN is defined; GREEN_TIME+PED_EXTRA must be <=127.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ns_ped_request  input  1  NS crosswalk button, level, synchronous.
- ew_ped_request  input  1  EW crosswalk button, level, synchronous.
- master_timer  output  7  seconds remaining in current phase; feeds pedestrian_light.
- ns_ped_enable  output  1  walk grant for NS crossing; feeds pedestrian_light enable.
- ew_ped_enable  output  1  walk grant for EW crossing.
- ns_light  output  3  {red,yellow,green}, one-hot.
- ew_light  output  3  {red,yellow,green}, one-hot.
- sec_tick  output  1  one-cycle pulse each second.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; ports are named clock and reset.
- Prescaler: counts 0..TICKS_PER_SEC-1 and wraps. sec_tick=1 in the cycle the count equals TICKS_PER_SEC-1.
- FSM state order: NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN.
- Phase timing:
  - On sec_tick with master_timer>1: master_timer decrements.
  - On sec_tick with master_timer==1: move to the next state and load that state's duration.
  - Each phase therefore shows D..1 and lasts exactly D seconds.
  - master_timer is never 0 after reset.
- Lights:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ew=001, ns=100.
  - EW_YELLOW: ew=010, ns=100.
  - ALL_RED_A and ALL_RED_B: both 100.
  - All outputs are registered.
- Request latching:
  - ns_pending sets on any cycle with ns_ped_request=1 while ns_ped_enable=0.
  - A request while ns_ped_enable=1 is ignored. EW is symmetric.
- Walk grant:
  - On the transition cycle into NS_GREEN: ns_ped_enable <= ns_pending | ns_ped_request, and ns_pending clears.
  - ns_ped_enable holds for the whole NS_GREEN phase and drops on the transition into NS_YELLOW. EW is symmetric.
  - The two enables are never both 1.
- Reset values:
  - state=ALL_RED_B, master_timer=ALL_RED_TIME, prescaler=0.
  - Both pending flags=0, both enables=0, both lights=100, sec_tick=0.
- Reset mid-phase: reset aborts immediately to the reset values; latched requests are lost.
- Simultaneous events:
  - A request in the same cycle as its green entry is granted.
  - A request in the same cycle as its green exit is latched for the next cycle of that direction.

Optional Feature:
- Macro: PED_EXTEND_EN.
- Defined: a green phase entered with its ped enable granted loads GREEN_TIME+PED_EXTRA.
- Undefined: every green phase loads GREEN_TIME regardless of requests.

Decomposition:
- Shared package/include (traffic_defs.v):
  - State encoding localparams (3-bit).
  - Light codes LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001.
  - Default phase durations.
- Sub-module sec_prescaler (parameter TICKS_PER_SEC; ports clock, reset, sec_tick) is natural and is reused by other timed blocks.

Test Plan:
- Reset with TICKS_PER_SEC=4, GREEN_TIME=5, YELLOW_TIME=2, ALL_RED_TIME=1 -> master_timer=1, both lights 100, enables 0. After 4 clocks, NS_GREEN with master_timer=5.
- Free run with no requests for one full cycle (5+2+1+5+2+1 = 16 s = 64 clocks):
  - State order and durations exact; enables stay 0.
  - Lights never show green or yellow in both directions at once.
- Pulse ew_ped_request for 1 cycle during NS_GREEN:
  - ew_ped_enable=1 for exactly EW_GREEN (20 clocks).
  - ns_ped_enable stays 0.
  - With PED_EXTEND_EN and PED_EXTRA=3, EW_GREEN lasts 32 clocks with timer starting at 8.
- Hold ns_ped_request=1 through NS_GREEN entry:
  - Granted on entry.
  - Request during the granted phase is not re-latched.
  - Releasing before NS_YELLOW means no grant in the next NS_GREEN.
- Assert reset for 1 cycle mid-EW_YELLOW with ns_pending=1 -> reset values restored; next NS_GREEN has ns_ped_enable=0.
- Check sec_tick is one cycle wide every 4 clocks, and master_timer changes only in sec_tick cycles.

Source files
------------

// File: rtl/intersection_controller_pkg.sv
// Shared phase encoding, light codes and default phase durations for the intersection controller.
package intersection_controller_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam int unsigned DEF_TICKS_PER_SEC = 50000000;
    localparam int unsigned DEF_GREEN_TIME    = 45;
    localparam int unsigned DEF_YELLOW_TIME   = 5;
    localparam int unsigned DEF_ALL_RED_TIME  = 2;
    localparam int unsigned DEF_PED_EXTRA     = 10;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:  next_phase = NS_YELLOW;
            NS_YELLOW: next_phase = ALL_RED_A;
            ALL_RED_A: next_phase = EW_GREEN;
            EW_GREEN:  next_phase = EW_YELLOW;
            EW_YELLOW: next_phase = ALL_RED_B;
            default:   next_phase = NS_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/intersection_controller_sec_prescaler.sv
// One-second tick generator: counts 0..TICKS_PER_SEC-1 and flags the last count.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic sec_tick
);

    localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign sec_tick = (count == LAST);

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer with latched pedestrian walk grants.
// Define PED_EXTEND_EN to lengthen a green phase by PED_EXTRA seconds when its walk is granted.
module intersection_controller
    import intersection_controller_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned GREEN_TIME    = DEF_GREEN_TIME,
    parameter int unsigned YELLOW_TIME   = DEF_YELLOW_TIME,
    parameter int unsigned ALL_RED_TIME  = DEF_ALL_RED_TIME,
    parameter int unsigned PED_EXTRA     = DEF_PED_EXTRA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ns_ped_request,
    input  logic       ew_ped_request,
    output logic [6:0] master_timer,
    output logic       ns_ped_enable,
    output logic       ew_ped_enable,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       sec_tick
);

`ifdef PED_EXTEND_EN
    localparam bit EXTEND = 1'b1;
`else
    localparam bit EXTEND = 1'b0;
`endif

    localparam logic [6:0] GREEN_LEN   = 7'(GREEN_TIME);
    localparam logic [6:0] GREEN_WALK  = 7'(GREEN_TIME + (EXTEND ? PED_EXTRA : 0));
    localparam logic [6:0] YELLOW_LEN  = 7'(YELLOW_TIME);
    localparam logic [6:0] ALL_RED_LEN = 7'(ALL_RED_TIME);

    phase_t     state, state_next;
    logic [6:0] timer_next;
    logic       ns_pending, ew_pending, ns_pending_next, ew_pending_next;
    logic       ns_enable_next, ew_enable_next;
    logic [2:0] ns_light_next, ew_light_next;
    logic       advance, ns_grant, ew_grant;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .sec_tick(sec_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ALL_RED_B;
            master_timer  <= ALL_RED_LEN;
            ns_pending    <= 1'b0;
            ew_pending    <= 1'b0;
            ns_ped_enable <= 1'b0;
            ew_ped_enable <= 1'b0;
            ns_light      <= LIGHT_RED;
            ew_light      <= LIGHT_RED;
        end else begin
            state         <= state_next;
            master_timer  <= timer_next;
            ns_pending    <= ns_pending_next;
            ew_pending    <= ew_pending_next;
            ns_ped_enable <= ns_enable_next;
            ew_ped_enable <= ew_enable_next;
            ns_light      <= ns_light_next;
            ew_light      <= ew_light_next;
        end
    end

    always_comb begin
        state_next      = state;
        timer_next      = master_timer;
        ns_pending_next = ns_pending;
        ew_pending_next = ew_pending;
        ns_enable_next  = ns_ped_enable;
        ew_enable_next  = ew_ped_enable;
        ns_light_next   = ns_light;
        ew_light_next   = ew_light;
        advance         = sec_tick && (master_timer == 7'd1);
        ns_grant        = ns_pending || ns_ped_request;
        ew_grant        = ew_pending || ew_ped_request;

        if (sec_tick && !advance)
            timer_next = master_timer - 7'd1;
        if (advance)
            state_next = next_phase(state);

        // A press on the green-exit cycle still counts even though the enable is high.
        if (ns_ped_request && (!ns_ped_enable || (advance && state == NS_GREEN)))
            ns_pending_next = 1'b1;
        if (ew_ped_request && (!ew_ped_enable || (advance && state == EW_GREEN)))
            ew_pending_next = 1'b1;

        if (advance && state == ALL_RED_B) begin
            ns_enable_next  = ns_grant;
            ns_pending_next = 1'b0;
        end else if (advance && state == NS_GREEN) begin
            ns_enable_next = 1'b0;
        end

        if (advance && state == ALL_RED_A) begin
            ew_enable_next  = ew_grant;
            ew_pending_next = 1'b0;
        end else if (advance && state == EW_GREEN) begin
            ew_enable_next = 1'b0;
        end

        if (advance) begin
            case (state_next)
                NS_GREEN:             timer_next = ns_grant ? GREEN_WALK : GREEN_LEN;
                EW_GREEN:             timer_next = ew_grant ? GREEN_WALK : GREEN_LEN;
                NS_YELLOW, EW_YELLOW: timer_next = YELLOW_LEN;
                default:              timer_next = ALL_RED_LEN;
            endcase
        end

        case (state_next)
            NS_GREEN:  begin ns_light_next = LIGHT_GREEN;  ew_light_next = LIGHT_RED;    end
            NS_YELLOW: begin ns_light_next = LIGHT_YELLOW; ew_light_next = LIGHT_RED;    end
            EW_GREEN:  begin ns_light_next = LIGHT_RED;    ew_light_next = LIGHT_GREEN;  end
            EW_YELLOW: begin ns_light_next = LIGHT_RED;    ew_light_next = LIGHT_YELLOW; end
            default:   begin ns_light_next = LIGHT_RED;    ew_light_next = LIGHT_RED;    end
        endcase
    end

endmodule
